// File: rtl/croc_pkg.sv
// Shared definitions for the croc pad controller: register map and pad output select encoding.
package croc_pkg;

  localparam logic [7:0] PadCtrlFuncSel0Offset  = 8'h00;
  localparam logic [7:0] PadCtrlFuncSel1Offset  = 8'h04;
  localparam logic [7:0] PadCtrlFiltEnOffset    = 8'h08;
  localparam logic [7:0] PadCtrlFiltLenOffset   = 8'h0C;
  localparam logic [7:0] PadCtrlIrqRiseEnOffset = 8'h10;
  localparam logic [7:0] PadCtrlIrqFallEnOffset = 8'h14;
  localparam logic [7:0] PadCtrlIrqStatusOffset = 8'h18;
  localparam logic [7:0] PadCtrlInRawOffset     = 8'h1C;

  typedef enum logic [1:0] {
    PadSelGpio = 2'd0,
    PadSelAlt0 = 2'd1,
    PadSelAlt1 = 2'd2,
    PadSelAlt2 = 2'd3
  } pad_sel_e;

endpackage

// File: rtl/croc_pad_in_filter.sv
// One pad input: two-flop synchroniser, run-length glitch filter and edge pulses on the filtered value.
module croc_pad_in_filter #(
  parameter int unsigned FilterWidth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pad_i,
  input  logic [FilterWidth-1:0] len_i,
  input  logic                   cnt_clr_i,
  output logic                   syn_o,
  output logic                   stb_o,
  output logic                   rise_o,
  output logic                   fall_o
);

  logic                   meta_q, syn_q, stb_q;
  logic [FilterWidth-1:0] cnt_q;
  logic                   upd;

  // stb follows syn once syn has differed for len_i+1 consecutive cycles
  assign upd = (syn_q != stb_q) && (cnt_q == len_i) && !cnt_clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      syn_q  <= 1'b0;
      stb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= pad_i;
      syn_q  <= meta_q;
      if (cnt_clr_i || (syn_q == stb_q)) begin
        cnt_q <= '0;
      end else if (upd) begin
        stb_q <= syn_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign syn_o  = syn_q;
  assign stb_o  = stb_q;
  assign rise_o = upd & syn_q;
  assign fall_o = upd & ~syn_q;

endmodule

// File: rtl/croc_pad_ctrl.sv
// Pad controller: register file, per-pad output source mux, filtered inputs and edge interrupt.
module croc_pad_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned NumPads     = 32,
  parameter int unsigned NumAltFn    = 2,
  parameter int unsigned FilterWidth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        reg_req_i,
  input  logic                        reg_we_i,
  input  logic [7:0]                  reg_addr_i,
  input  logic [31:0]                 reg_wdata_i,
  output logic                        reg_gnt_o,
  output logic                        reg_rvalid_o,
  output logic [31:0]                 reg_rdata_o,
  input  logic [NumPads-1:0]          gpio_o_i,
  input  logic [NumPads-1:0]          gpio_oe_i,
  output logic [NumPads-1:0]          gpio_in_o,
  input  logic [NumAltFn*NumPads-1:0] alt_o_i,
  input  logic [NumAltFn*NumPads-1:0] alt_oe_i,
  output logic [NumPads-1:0]          pad_c2p_o,
  output logic [NumPads-1:0]          pad_c2p_en_o,
  input  logic [NumPads-1:0]          pad_p2c_i,
  output logic                        irq_o
);

  logic [NumPads-1:0]     funcsel0_q, funcsel1_q, filt_en_q, rise_en_q, fall_en_q, status_q;
  logic [FilterWidth-1:0] filt_len_q;
  logic                   filt_clr_q, rvalid_q, irq_q;
  logic [31:0]            rdata_q, rdata_d;
  logic [NumPads-1:0]     syn, stb, rise, fall, hw_set, w1c;
  logic                   wr;
  logic [5:0]             word;
  logic                   unused_addr;

  assign wr          = reg_req_i & reg_we_i;
  assign word        = reg_addr_i[7:2];
  assign unused_addr = ^reg_addr_i[1:0];

  always_comb begin
    rdata_d = '0;
    case (word)
      PadCtrlFuncSel0Offset[7:2]:  rdata_d = 32'(funcsel0_q);
      PadCtrlFuncSel1Offset[7:2]:  rdata_d = 32'(funcsel1_q);
      PadCtrlFiltEnOffset[7:2]:    rdata_d = 32'(filt_en_q);
      PadCtrlFiltLenOffset[7:2]:   rdata_d = 32'(filt_len_q);
      PadCtrlIrqRiseEnOffset[7:2]: rdata_d = 32'(rise_en_q);
      PadCtrlIrqFallEnOffset[7:2]: rdata_d = 32'(fall_en_q);
      PadCtrlIrqStatusOffset[7:2]: rdata_d = 32'(status_q);
      PadCtrlInRawOffset[7:2]:     rdata_d = 32'(syn);
      default:                     rdata_d = '0;
    endcase
  end

  assign w1c    = (wr && word == PadCtrlIrqStatusOffset[7:2]) ? reg_wdata_i[NumPads-1:0] : '0;
  assign hw_set = (rise & rise_en_q) | (fall & fall_en_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funcsel0_q <= '0;
      funcsel1_q <= '0;
      filt_en_q  <= '0;
      filt_len_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      filt_clr_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      rvalid_q   <= reg_req_i;
      rdata_q    <= (reg_req_i && !reg_we_i) ? rdata_d : '0;
      filt_clr_q <= wr && (word == PadCtrlFiltEnOffset[7:2] || word == PadCtrlFiltLenOffset[7:2]);
      irq_q      <= |(status_q & (rise_en_q | fall_en_q));
      // a hardware set in the same cycle as a clear keeps the bit set
      status_q   <= (status_q & ~w1c) | hw_set;
      if (wr) begin
        case (word)
          PadCtrlFuncSel0Offset[7:2]:  funcsel0_q <= reg_wdata_i[NumPads-1:0];
          PadCtrlFuncSel1Offset[7:2]:  funcsel1_q <= reg_wdata_i[NumPads-1:0];
          PadCtrlFiltEnOffset[7:2]:    filt_en_q  <= reg_wdata_i[NumPads-1:0];
          PadCtrlFiltLenOffset[7:2]:   filt_len_q <= reg_wdata_i[FilterWidth-1:0];
          PadCtrlIrqRiseEnOffset[7:2]: rise_en_q  <= reg_wdata_i[NumPads-1:0];
          PadCtrlIrqFallEnOffset[7:2]: fall_en_q  <= reg_wdata_i[NumPads-1:0];
          default: ;
        endcase
      end
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign irq_o        = irq_q;
  assign gpio_in_o    = stb;

  // select index 0 is GPIO, 1..NumAltFn the alternates, anything above is tied off
  logic [3:0][NumPads-1:0] src_o, src_oe;

  assign src_o[0]  = gpio_o_i;
  assign src_oe[0] = gpio_oe_i;

  for (genvar k = 0; k < 3; k++) begin : g_src
    if (k < NumAltFn) begin : g_alt
      assign src_o[k+1]  = alt_o_i[k*NumPads +: NumPads];
      assign src_oe[k+1] = alt_oe_i[k*NumPads +: NumPads];
    end else begin : g_tie
      assign src_o[k+1]  = '0;
      assign src_oe[k+1] = '0;
    end
  end

  for (genvar p = 0; p < NumPads; p++) begin : g_pad
    logic [FilterWidth-1:0] eff_len;
    pad_sel_e               sel;

    assign eff_len = filt_en_q[p] ? filt_len_q : '0;
    assign sel     = pad_sel_e'({funcsel1_q[p], funcsel0_q[p]});

    assign pad_c2p_o[p]    = src_o[sel][p];
    assign pad_c2p_en_o[p] = src_oe[sel][p];

    croc_pad_in_filter #(.FilterWidth(FilterWidth)) i_filter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .pad_i     (pad_p2c_i[p]),
      .len_i     (eff_len),
      .cnt_clr_i (filt_clr_q),
      .syn_o     (syn[p]),
      .stb_o     (stb[p]),
      .rise_o    (rise[p]),
      .fall_o    (fall[p])
    );
  end

endmodule

// File: tb/tb_croc_pad_ctrl.sv
// Bench for croc_pad_ctrl: directed scenarios plus random traffic against a history-window reference model.
module tb_croc_pad_ctrl;

  localparam int NP = 32;
  localparam int NA = 2;
  localparam int FW = 4;

  localparam logic [7:0] A_FS0  = 8'h00;
  localparam logic [7:0] A_FS1  = 8'h04;
  localparam logic [7:0] A_FEN  = 8'h08;
  localparam logic [7:0] A_FLEN = 8'h0C;
  localparam logic [7:0] A_REN  = 8'h10;
  localparam logic [7:0] A_STAT = 8'h18;

  logic             clk = 1'b0, rst_n = 1'b1;
  logic             req = 1'b0, we = 1'b0;
  logic [7:0]       addr = '0;
  logic [31:0]      wdata = '0;
  logic             gnt, rvalid, irq;
  logic [31:0]      rdata;
  logic [NP-1:0]    gpio_o = '0, gpio_oe = '0, p2c = '0;
  logic [NP-1:0]    gpio_in, c2p, c2p_en;
  logic [NA*NP-1:0] alt_o = '0, alt_oe = '0;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  croc_pad_ctrl #(.NumPads(NP), .NumAltFn(NA), .FilterWidth(FW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_gnt_o(gnt), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata),
    .gpio_o_i(gpio_o), .gpio_oe_i(gpio_oe), .gpio_in_o(gpio_in),
    .alt_o_i(alt_o), .alt_oe_i(alt_oe),
    .pad_c2p_o(c2p), .pad_c2p_en_o(c2p_en), .pad_p2c_i(p2c),
    .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain variables, pad inputs as a sample history.
  logic [NP-1:0] m_fs0, m_fs1, m_fen, m_ren, m_fall, m_stat, m_stb;
  logic [FW-1:0] m_flen;
  logic          m_irq, m_rvalid;
  logic [31:0]   m_rdata;
  logic [NP-1:0] pad_at [32];
  int            ec, last_clr;
  bit            clr_pend;
  bit            chk_on = 0;

  // synchronised value seen just before edge k is the pad sampled two edges earlier
  function automatic logic [NP-1:0] syn_at(int k);
    return (k < 2) ? '0 : pad_at[(k - 2) % 32];
  endfunction

  function automatic logic [31:0] reg_read(logic [7:0] a, logic [NP-1:0] syn);
    case (a[7:2])
      6'd0:    return 32'(m_fs0);
      6'd1:    return 32'(m_fs1);
      6'd2:    return 32'(m_fen);
      6'd3:    return 32'(m_flen);
      6'd4:    return 32'(m_ren);
      6'd5:    return 32'(m_fall);
      6'd6:    return 32'(m_stat);
      6'd7:    return 32'(syn);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NP-1:0] mux_exp(bit oe);
    logic [NP-1:0] r;
    int sel;
    for (int p = 0; p < NP; p++) begin
      sel = 2 * int'(m_fs1[p]) + int'(m_fs0[p]);
      if (sel == 0)       r[p] = oe ? gpio_oe[p] : gpio_o[p];
      else if (sel <= NA) r[p] = oe ? alt_oe[(sel-1)*NP + p] : alt_o[(sel-1)*NP + p];
      else                r[p] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_fs0 = '0; m_fs1 = '0; m_fen = '0; m_ren = '0; m_fall = '0; m_stat = '0; m_stb = '0;
    m_flen = '0; m_irq = 0; m_rvalid = 0; m_rdata = '0;
    ec = 0; last_clr = -1; clr_pend = 0;
  endtask

  // Predicts state after the coming edge from the inputs that edge will sample.
  task automatic model_step();
    logic [NP-1:0] syn_now, nxt, set, w1c, s;
    int L;
    bit ok;
    if (clr_pend) begin last_clr = ec; clr_pend = 0; end
    pad_at[ec % 32] = p2c;
    syn_now = syn_at(ec);
    nxt = m_stb;
    set = '0;
    for (int p = 0; p < NP; p++) begin
      L  = m_fen[p] ? int'(m_flen) : 0;
      ok = (ec - L > last_clr);
      for (int k = ec - L; k <= ec; k++) begin
        s = syn_at(k);
        if (s[p] == m_stb[p]) ok = 0;
      end
      if (ok) begin
        nxt[p] = ~m_stb[p];
        if ((nxt[p] && m_ren[p]) || (!nxt[p] && m_fall[p])) set[p] = 1'b1;
      end
    end
    m_irq    = |(m_stat & (m_ren | m_fall));
    m_rvalid = req;
    m_rdata  = (req && !we) ? reg_read(addr, syn_now) : 32'h0;
    w1c      = (req && we && addr[7:2] == 6'd6) ? wdata[NP-1:0] : '0;
    m_stat   = (m_stat & ~w1c) | set;
    m_stb    = nxt;
    if (req && we) begin
      case (addr[7:2])
        6'd0: m_fs0 = wdata[NP-1:0];
        6'd1: m_fs1 = wdata[NP-1:0];
        6'd2: begin m_fen = wdata[NP-1:0]; clr_pend = 1; end
        6'd3: begin m_flen = wdata[FW-1:0]; clr_pend = 1; end
        6'd4: m_ren = wdata[NP-1:0];
        6'd5: m_fall = wdata[NP-1:0];
        default: ;
      endcase
    end
    ec++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (chk_on) begin
          chk("gnt", gnt, req);
          chk("gpio_in", gpio_in, m_stb);
          chk("irq", irq, m_irq);
          chk("rvalid", rvalid, m_rvalid);
          chk("rdata", rdata, m_rdata);
          chk("c2p", c2p, mux_exp(0));
          chk("c2p_en", c2p_en, mux_exp(1));
        end
        model_step();
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d);
    req = 1; we = w; addr = a; wdata = d;
    cyc();
    req = 0; we = 0;
  endtask

  task automatic wait_in(input int p, input logic v, output int n);
    n = 0;
    while (gpio_in[p] !== v && n < 40) begin
      cyc();
      n++;
    end
  endtask

  int  n;
  bit  seen;

  initial begin
    gpio_o = $urandom; gpio_oe = $urandom;
    #2 rst_n = 0;
    #1;
    chk("rst_c2p_en", c2p_en, gpio_oe);
    chk("rst_c2p", c2p, gpio_o);
    chk("rst_gpio_in", gpio_in, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1; chk_on = 1;

    // all registers read zero, response one cycle after the grant
    for (int i = 0; i < 8; i++) begin
      bus(0, 8'(i * 4), 32'h0);
      chk("rd_rvalid", rvalid, 1);
      chk("rd_zero", rdata, 0);
    end
    bus(0, 8'h3C, 32'h0);
    chk("rd_unmapped", rdata, 0);
    cyc();
    chk("rvalid_drop", rvalid, 0);

    // output mux
    bus(1, A_FS0, 32'h1);
    bus(1, A_FS1, 32'h2);
    gpio_o = '0; gpio_oe = '0;
    alt_o  = 64'h0000_0002_0000_0001;
    alt_oe = 64'h0000_0002_0000_0001;
    #1;
    chk("alt_c2p", 32'(c2p[1:0]), 3);
    chk("alt_en", 32'(c2p_en[1:0]), 3);
    cyc();
    bus(1, A_FS0, 32'h4);
    bus(1, A_FS1, 32'h4);
    gpio_o = '1; gpio_oe = '1; alt_o = '1; alt_oe = '1;
    #1;
    chk("tie_c2p", 32'(c2p[2]), 0);
    chk("tie_en", 32'(c2p_en[2]), 0);
    cyc();

    // unfiltered latency, then filtered pulses
    p2c[5] = 1; wait_in(5, 1, n); chk("lat_rise", n, 3);
    p2c[5] = 0; wait_in(5, 0, n); chk("lat_fall", n, 3);
    bus(1, A_FEN, 32'h20);
    bus(1, A_FLEN, 32'h4);
    repeat (3) cyc();
    p2c[5] = 1; repeat (4) cyc(); p2c[5] = 0;
    seen = 0;
    repeat (12) begin seen |= gpio_in[5]; cyc(); end
    chk("pulse4_blocked", seen, 0);
    p2c[5] = 1; n = 0;
    while (gpio_in[5] !== 1'b1 && n < 30) begin
      cyc(); n++;
      if (n == 5) p2c[5] = 0;
    end
    chk("pulse5_lat", n, 7);
    repeat (20) cyc();

    // interrupt set, clear, and clear racing a new edge
    bus(1, A_REN, 32'h8);
    p2c[3] = 1; wait_in(3, 1, n); chk("irq_pad_lat", n, 3);
    bus(0, A_STAT, 32'h0);
    chk("stat_set", rdata, 32'h8);
    chk("irq_set", irq, 1);
    bus(1, A_STAT, 32'h8);
    cyc();
    chk("irq_clr", irq, 0);
    p2c[3] = 0; wait_in(3, 0, n);
    repeat (2) cyc();
    p2c[3] = 1; cyc(); cyc();
    bus(1, A_STAT, 32'h8);
    bus(0, A_STAT, 32'h0);
    chk("set_beats_w1c", rdata, 32'h8);
    cyc();

    // reset in the middle of a filter run and a read
    p2c[5] = 1; repeat (4) cyc();
    req = 1; we = 0; addr = A_STAT; cyc(); req = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_gpio_in", gpio_in, 0);
    chk("arst_irq", irq, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_c2p_en", c2p_en, gpio_oe);
    @(posedge clk); #1 rst_n = 1;
    wait_in(5, 1, n); chk("restart_lat", n, 3);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      gpio_o = $urandom; gpio_oe = $urandom;
      alt_o = {$urandom, $urandom}; alt_oe = {$urandom, $urandom};
      p2c ^= $urandom & $urandom & $urandom;
      if ($urandom_range(0, 2) == 0) begin
        req = 1; we = $urandom_range(0, 1) == 1; wdata = $urandom;
        addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {3'b000, 3'($urandom_range(0, 7)), 2'b00};
      end else begin
        req = 0; we = 0;
      end
      cyc();
    end
    req = 0; we = 0;
    repeat (30) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
